// File: rtl/mpadder_arbiter_pkg.sv
// mpadder_arbiter_pkg: shared widths, FSM state encodings and round-robin wrap helper
package mpadder_arbiter_pkg;
  localparam int OP_W_DEF = 1027;
  localparam int RES_W_DEF = OP_W_DEF + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  function automatic int rr_wrap(input int x, input int n);
    return (x >= n) ? x - n : x;
  endfunction
endpackage

// File: rtl/mpadder_arbiter_rr_pick.sv
// mpadder_arbiter_rr_pick: combinational round-robin picker (req_i, ptr_i -> one-hot gnt_o, idx_o, any_o)
module mpadder_arbiter_rr_pick
  import mpadder_arbiter_pkg::*;
#(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'(rr_wrap(int'(ptr_i) + i, N));
      if (req_i[j]) idx_o = j;
    end
    any_o = |req_i;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/mpadder_arbiter.sv
// mpadder_arbiter: round-robin sharing of one registered add/sub unit between N_REQ requesters with done timeout
module mpadder_arbiter
  import mpadder_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int OP_W = OP_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_sub,
  input  logic [N_REQ*OP_W-1:0] req_a,
  input  logic [N_REQ*OP_W-1:0] req_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [RES_W-1:0]   rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic               err_timeout,
  output logic               add_start,
  output logic               add_subtract,
  output logic [OP_W-1:0]    add_in_a,
  output logic [OP_W-1:0]    add_in_b,
  input  logic [RES_W-1:0]   add_result,
  input  logic               add_done
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0] state_q, state_d;
  logic [IW-1:0] ptr_q, owner_q, win_idx;
  logic [N_REQ-1:0] win_oh, gnt_q, rsp_valid_q;
  logic win_any, timeout;
  logic [CW-1:0] cnt_q;
  logic [OP_W-1:0] a_q, b_q;
  logic sub_q, start_q, rsp_err_q, err_q;
  logic [RES_W-1:0] res_q;
  mpadder_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(win_oh),
    .idx_o(win_idx),
    .any_o(win_any)
  );
  // done arriving in the last permitted WAIT cycle suppresses the timeout
  assign timeout = (state_q == S_WAIT) && !add_done && (cnt_q == CW'(TIMEOUT - 1));
  assign state_d = (state_q == S_IDLE)  ? (win_any ? S_ISSUE : S_IDLE) :
                   (state_q == S_ISSUE) ? S_WAIT :
                   (state_q == S_WAIT)  ? ((add_done || timeout) ? S_RESP : S_WAIT) :
                   S_IDLE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      start_q <= 1'b0;
      rsp_err_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= '0;
      start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q <= 1'b0;
      if (state_q == S_IDLE && win_any) begin
        a_q <= req_a[win_idx*OP_W +: OP_W];
        b_q <= req_b[win_idx*OP_W +: OP_W];
        sub_q <= req_sub[win_idx];
        owner_q <= win_idx;
        gnt_q <= win_oh;
      end
      if (state_q == S_ISSUE) begin
        start_q <= 1'b1;
        cnt_q <= '0;
      end
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + CW'(1);
        if (add_done || timeout) begin
          res_q <= add_done ? add_result : '0;
          rsp_err_q <= !add_done;
          err_q <= err_q | !add_done;
          rsp_valid_q <= N_REQ'(1) << owner_q;
        end
      end
      if (state_q == S_RESP) ptr_q <= (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
    end
  end
  assign gnt = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_result = res_q;
  assign rsp_err = rsp_err_q;
  assign busy = state_q != S_IDLE;
  assign err_timeout = err_q;
  assign add_start = start_q;
  assign add_subtract = sub_q;
  assign add_in_a = a_q;
  assign add_in_b = b_q;
endmodule

// File: tb/tb_mpadder_arbiter.sv
// tb_mpadder_arbiter: table-driven, corner-sequence and randomized model check of mpadder_arbiter
module tb_mpadder_arbiter;
  localparam int N = 3;
  localparam int OP_W = 1027;
  localparam int RES_W = 1028;
  localparam int TO = 8;
  typedef struct {
    int idx;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic sub;
    logic [RES_W-1:0] res;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic resetn;
  logic [N-1:0] req, req_sub;
  logic [N*OP_W-1:0] req_a, req_b;
  logic [N-1:0] gnt, rsp_valid;
  logic [RES_W-1:0] rsp_result, add_result;
  logic rsp_err, busy, err_timeout, add_start, add_subtract;
  logic [OP_W-1:0] add_in_a, add_in_b;
  logic add_done = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  bit stub_en;
  int stub_dly;
  bit inj_done;
  int sc = 0;
  vec_t tbl[7];
  logic [OP_W-1:0] pa[N], pb[N];
  logic ps[N];
  int own_q[$];
  logic [RES_W-1:0] res_exp_q[$];
  always #5 clk = ~clk;
  mpadder_arbiter #(.N_REQ(N), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .err_timeout(err_timeout), .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b), .add_result(add_result), .add_done(add_done)
  );
  // stand-in adder: combinational result, done pulse stub_dly cycles after start
  assign add_result = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b}) : ({1'b0, add_in_a} + {1'b0, add_in_b});
  always @(posedge clk) begin
    add_done <= inj_done;
    if (sc == 1) add_done <= 1'b1;
    if (sc > 0) sc <= sc - 1;
    if (add_start && stub_en) begin
      if (stub_dly == 1) add_done <= 1'b1;
      else sc <= stub_dly - 1;
    end
  end
  function automatic logic [RES_W-1:0] model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic s);
    logic [RES_W:0] full;
    full = s ? ({2'b0, a} + (2**(RES_W) ) - {2'b0, b}) : ({2'b0, a} + {2'b0, b});
    return full[RES_W-1:0];
  endfunction
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [OP_W-1:0] rand_op();
    logic [1055:0] t;
    for (int k = 0; k < 33; k++) t[k*32 +: 32] = $urandom;
    if ($urandom_range(0, 3) == 0) t = '1;
    return t[OP_W-1:0];
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_w(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got msb=%b low=%h want msb=%b low=%h", nm, act[RES_W-1], act[127:0], exp[RES_W-1], exp[127:0]);
    end
  endtask
  task automatic drive(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic s);
    req_a[i*OP_W +: OP_W] = a;
    req_b[i*OP_W +: OP_W] = b;
    req_sub[i] = s;
  endtask
  task automatic wait_rsp(input string nm, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (|rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no rsp_valid want pulse within 40 cycles", nm);
    end
  endtask
  task automatic wait_gnt(input string nm, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (|gnt) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no gnt want pulse within 40 cycles", nm);
    end
  endtask
  task automatic run_op(input vec_t v, input string nm);
    bit ok;
    logic [N-1:0] oh;
    oh = 3'b001 << v.idx;
    @(negedge clk);
    drive(v.idx, v.a, v.b, v.sub);
    req = oh;
    @(negedge clk);
    chk({nm, "_gnt"}, 64'(gnt), 64'(oh));
    req = '0;
    chk_w({nm, "_in_a"}, {1'b0, add_in_a}, {1'b0, v.a});
    chk({nm, "_subsel"}, 64'(add_subtract), 64'(v.sub));
    @(negedge clk);
    chk({nm, "_start"}, 64'(add_start), 64'd1);
    chk({nm, "_gnt_pulse"}, 64'(gnt), 64'd0);
    wait_rsp(nm, ok);
    if (ok) begin
      chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
      chk_w({nm, "_result"}, rsp_result, v.res);
      chk({nm, "_rsp_err"}, 64'(rsp_err), 64'(v.err));
    end
    @(negedge clk);
    chk({nm, "_valid_pulse"}, 64'(rsp_valid), 64'd0);
    chk_w({nm, "_hold"}, rsp_result, v.res);
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1);
  end
  initial begin
    bit ok;
    logic [OP_W-1:0] cap_a, cap_b;
    vec_t v;
    bit mfree, free_nx, exp_g;
    int mptr, nops, w, o;
    logic [N-1:0] req_prev;
    resetn = 1'b0;
    req = '0;
    req_sub = '0;
    req_a = '0;
    req_b = '0;
    stub_en = 1'b1;
    stub_dly = 1;
    inj_done = 1'b0;
    tbl[0] = '{0, OP_W'(5), OP_W'(3), 1'b0, RES_W'(8), 1'b0};
    tbl[1] = '{0, OP_W'(3), OP_W'(5), 1'b1, {RES_W{1'b1}} - RES_W'(1), 1'b0};
    tbl[2] = '{1, OP_W'(1) << 1026, OP_W'(1), 1'b1, (RES_W'(1) << 1026) - RES_W'(1), 1'b0};
    tbl[3] = '{2, {OP_W{1'b1}}, {OP_W{1'b1}}, 1'b0, {RES_W{1'b1}} - RES_W'(1), 1'b0};
    tbl[4] = '{1, {OP_W{1'b1}}, OP_W'(0), 1'b1, {1'b0, {OP_W{1'b1}}}, 1'b0};
    tbl[5] = '{2, OP_W'(0), OP_W'(0), 1'b1, RES_W'(0), 1'b0};
    tbl[6] = '{0, OP_W'(0), OP_W'(1), 1'b1, {RES_W{1'b1}}, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_start", 64'(add_start), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk_w("rst_result", rsp_result, '0);
    chk_w("rst_in_a", {1'b0, add_in_a}, '0);
    resetn = 1'b1;
    for (int i = 0; i < 7; i++) run_op(tbl[i], $sformatf("tbl%0d", i));
    // operand stability while requester keeps changing its operand
    stub_dly = 3;
    cap_a = rand_op();
    cap_b = rand_op();
    @(negedge clk);
    drive(1, cap_a, cap_b, 1'b0);
    req = 3'b010;
    wait_gnt("stab_gnt", ok);
    req = '0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      chk_w("stab_in_a", {1'b0, add_in_a}, {1'b0, cap_a});
      req_a[OP_W +: OP_W] = rand_op();
      @(negedge clk);
      if (|rsp_valid) ok = 1'b1;
    end
    chk("stab_seen", 64'(ok), 64'd1);
    chk_w("stab_in_a_resp", {1'b0, add_in_a}, {1'b0, cap_a});
    chk_w("stab_result", rsp_result, model(cap_a, cap_b, 1'b0));
    // fairness from rr_ptr = 0 with all requesters held high
    do_reset();
    stub_dly = 1;
    for (int i = 0; i < N; i++) drive(i, OP_W'(100 + i), OP_W'(i), 1'b0);
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_gnt($sformatf("fair%0d_gnt", k), ok);
      chk($sformatf("fair%0d_gnt", k), 64'(gnt), 64'(3'b001 << (k % N)));
      wait_rsp($sformatf("fair%0d_rsp", k), ok);
      chk($sformatf("fair%0d_rsp", k), 64'(rsp_valid), 64'(3'b001 << (k % N)));
      chk_w($sformatf("fair%0d_res", k), rsp_result, RES_W'(100 + 2 * (k % N)));
    end
    req = '0;
    // done outside WAIT has no effect
    @(negedge clk);
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk("stray_done_busy", 64'(busy), 64'd0);
    chk("stray_done_valid", 64'(rsp_valid), 64'd0);
    // timeout, then recovery
    stub_en = 1'b0;
    v = '{0, OP_W'(7), OP_W'(9), 1'b0, RES_W'(0), 1'b1};
    run_op(v, "tmo");
    chk("tmo_sticky", 64'(err_timeout), 64'd1);
    stub_en = 1'b1;
    v = '{1, OP_W'(10), OP_W'(20), 1'b0, RES_W'(30), 1'b0};
    run_op(v, "post_tmo");
    chk("post_tmo_sticky", 64'(err_timeout), 64'd1);
    // done coinciding with the last WAIT cycle wins over the timeout
    stub_dly = TO - 1;
    v = '{2, OP_W'(40), OP_W'(2), 1'b1, RES_W'(38), 1'b0};
    run_op(v, "edge_done");
    stub_dly = 1;
    // reset in WAIT: owner 0 served first so rr_ptr is 1 before the abort
    v = '{0, OP_W'(1), OP_W'(1), 1'b0, RES_W'(2), 1'b0};
    run_op(v, "pre_rst");
    stub_en = 1'b0;
    @(negedge clk);
    drive(1, OP_W'(55), OP_W'(5), 1'b0);
    req = 3'b010;
    wait_gnt("abort_gnt", ok);
    req = '0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_start", 64'(add_start), 64'd0);
    chk("abort_valid", 64'(rsp_valid), 64'd0);
    chk("abort_err", 64'(err_timeout), 64'd0);
    chk_w("abort_in_a", {1'b0, add_in_a}, '0);
    chk_w("abort_in_b", {1'b0, add_in_b}, '0);
    @(negedge clk);
    resetn = 1'b1;
    stub_en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (|rsp_valid) ok = 1'b1;
    end
    chk("abort_no_rsp", 64'(ok), 64'd0);
    drive(0, OP_W'(4), OP_W'(4), 1'b0);
    drive(2, OP_W'(6), OP_W'(6), 1'b0);
    req = 3'b101;
    @(negedge clk);
    chk("after_rst_ptr", 64'(gnt), 64'b001);
    req = '0;
    wait_rsp("after_rst_rsp", ok);
    chk_w("after_rst_res", rsp_result, RES_W'(8));
    v = '{2, OP_W'(6), OP_W'(6), 1'b0, RES_W'(12), 1'b0};
    run_op(v, "sole2");
    // randomized traffic against a transaction-level round-robin model
    do_reset();
    mfree = 1'b1;
    free_nx = 1'b0;
    exp_g = 1'b0;
    mptr = 0;
    nops = 0;
    req_prev = '0;
    for (int c = 0; c < 3000 && nops < 40; c++) begin
      @(negedge clk);
      stub_dly = $urandom_range(1, 5);
      if (free_nx) begin
        mfree = 1'b1;
        free_nx = 1'b0;
      end
      if (exp_g) begin
        w = pick(req_prev, mptr);
        chk("rnd_gnt", 64'(gnt), 64'(3'b001 << w));
        own_q.push_back(w);
        res_exp_q.push_back(model(pa[w], pb[w], ps[w]));
        req[w] = 1'b0;
        mfree = 1'b0;
      end else if (|gnt) chk("rnd_unexpected_gnt", 64'(gnt), 64'd0);
      if (|rsp_valid) begin
        if (own_q.size() == 0) chk("rnd_unexpected_rsp", 64'(rsp_valid), 64'd0);
        else begin
          o = own_q.pop_front();
          chk("rnd_rsp_owner", 64'(rsp_valid), 64'(3'b001 << o));
          chk_w("rnd_result", rsp_result, res_exp_q.pop_front());
          chk("rnd_rsp_err", 64'(rsp_err), 64'd0);
          mptr = (o + 1) % N;
        end
        free_nx = 1'b1;
        nops++;
      end
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          pa[i] = rand_op();
          pb[i] = rand_op();
          ps[i] = 1'($urandom_range(0, 1));
          drive(i, pa[i], pb[i], ps[i]);
          req[i] = 1'b1;
        end
      req_prev = req;
      exp_g = mfree && (|req);
    end
    chk("rnd_ops", 64'(nops), 64'd40);
    req = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
